// File: rtl/game_state_ctrl.sv
// Top-level game sequencer for the VGA shooter: lives, score, waves, pause and invulnerability.
// Latency: one cycle from any input to state/score/lives/wave/respawn; freeze/colour decode from state_q.
// No backpressure: inputs are single-cycle pulses sampled every clk edge and never stalled.
module game_state_ctrl #(
    parameter int N_ENEMIES    = 3,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 16,
    parameter int WAVE_KILLS   = 10,
    parameter int WAVE_W       = 4,
    parameter int INVULN_TICKS = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause_btn,
    input  logic                 frame_tick,
    input  logic [N_ENEMIES-1:0] enemy_hit,
    input  logic [N_ENEMIES-1:0] enemy_breach,
    output logic [2:0]           state,
    output logic                 freeze,
    output logic [3:0]           lives,
    output logic [SCORE_W-1:0]   score,
    output logic [WAVE_W-1:0]    wave,
    output logic [N_ENEMIES-1:0] enemy_respawn,
    output logic [7:0]           bg_color,
    output logic                 game_end
);

    localparam int CNT_W  = $clog2(N_ENEMIES + 1);
    localparam int KILL_W = $clog2(WAVE_KILLS + N_ENEMIES + 1);
    localparam int TICK_W = $clog2(INVULN_TICKS + 1);

    typedef enum logic [2:0] {
        ST_HOME  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HIT   = 3'd3,
        ST_END   = 3'd4
    } state_e;

    state_e               state_q,   state_d;
    logic [3:0]           lives_q,   lives_d;
    logic [SCORE_W-1:0]   score_q,   score_d;
    logic [WAVE_W-1:0]    wave_q,    wave_d;
    logic [KILL_W-1:0]    kills_q,   kills_d;
    logic [TICK_W-1:0]    tick_q,    tick_d;
    logic [N_ENEMIES-1:0] respawn_q, respawn_d;

    // Scoring candidates, used only when the FSM accepts hits this cycle
    logic [N_ENEMIES-1:0] kill_mask;
    logic [CNT_W-1:0]     n_kill;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [KILL_W-1:0]    kill_acc;
    logic [WAVE_W-1:0]    wave_acc;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_ENEMIES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Kill accounting: a breach on the same enemy cancels its hit; score and wave saturate
    always_comb begin
        kill_mask = enemy_hit & ~enemy_breach;
        n_kill    = popcount(kill_mask);
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(n_kill);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        kill_acc  = kills_q + KILL_W'(n_kill);
        wave_acc  = wave_q;
        // Several wave boundaries can be crossed in one cycle when WAVE_KILLS is smaller
        // than the enemy count; this keeps kills_q below WAVE_KILLS at all times.
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (kill_acc >= KILL_W'(WAVE_KILLS)) begin
                kill_acc = kill_acc - KILL_W'(WAVE_KILLS);
                if (wave_acc != {WAVE_W{1'b1}}) begin
                    wave_acc = wave_acc + WAVE_W'(1);
                end
            end
        end
    end

    // Next-state logic; start low always wins and discards that cycle's hits/breaches
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        wave_d    = wave_q;
        kills_d   = kills_q;
        tick_d    = tick_q;
        respawn_d = '0;
        case (state_q)
            ST_HOME: begin
                if (start) begin
                    state_d   = ST_PLAY;
                    lives_d   = 4'(LIVES);
                    score_d   = '0;
                    wave_d    = WAVE_W'(1);
                    kills_d   = '0;
                    tick_d    = '0;
                    respawn_d = '1;
                end
            end
            ST_PLAY: begin
                if (!start) begin
                    state_d = ST_HOME;
                end else begin
                    respawn_d = enemy_hit | enemy_breach;
                    score_d   = score_sat;
                    kills_d   = kill_acc;
                    wave_d    = wave_acc;
                    if (|enemy_breach) begin
                        // One life per cycle no matter how many enemies got through
                        if (lives_q <= 4'd1) begin
                            lives_d = '0;
                            state_d = ST_END;
                        end else begin
                            lives_d = lives_q - 4'd1;
                            state_d = ST_HIT;
                            tick_d  = '0;
                        end
                    end else if (pause_btn) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_HIT: begin
                if (!start) begin
                    state_d = ST_HOME;
                end else begin
                    // Invulnerable: breaches only respawn, pause is ignored
                    respawn_d = enemy_hit | enemy_breach;
                    score_d   = score_sat;
                    kills_d   = kill_acc;
                    wave_d    = wave_acc;
                    if (frame_tick) begin
                        if (tick_q == TICK_W'(INVULN_TICKS - 1)) begin
                            state_d = ST_PLAY;
                            tick_d  = '0;
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (!start) begin
                    state_d = ST_HOME;
                end else if (pause_btn) begin
                    state_d = ST_PLAY;
                end
            end
            ST_END: begin
                if (!start) begin
                    state_d = ST_HOME;
                end
            end
            default: begin
                state_d = ST_HOME;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOME;
            lives_q   <= '0;
            score_q   <= '0;
            wave_q    <= '0;
            kills_q   <= '0;
            tick_q    <= '0;
            respawn_q <= '0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            wave_q    <= wave_d;
            kills_q   <= kills_d;
            tick_q    <= tick_d;
            respawn_q <= respawn_d;
        end
    end

    // Mover freeze, background colour and end flag decoded from the registered state
    always_comb begin
        freeze   = 1'b1;
        bg_color = 8'hFF;
        game_end = 1'b0;
        case (state_q)
            ST_PLAY: begin
                freeze   = 1'b0;
                bg_color = 8'h00;
            end
            ST_PAUSE: begin
                bg_color = 8'h49;
            end
            ST_HIT: begin
                freeze   = 1'b0;
                bg_color = 8'hE0;
            end
            ST_END: begin
                bg_color = 8'hE0;
                game_end = 1'b1;
            end
            default: begin
                freeze   = 1'b1;
                bg_color = 8'hFF;
            end
        endcase
    end

    assign state         = state_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign wave          = wave_q;
    assign enemy_respawn = respawn_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: scenario tasks drive one cycle at a time through a reference model.
// Expected output snapshots are queued at drive time and compared one cycle later by a monitor.
// Tasks also make targeted inline checks of the headline values of each scenario.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, pause_btn, frame_tick;
    logic [2:0]  enemy_hit, enemy_breach;
    logic [2:0]  state;
    logic        freeze;
    logic [3:0]  lives;
    logic [15:0] score;
    logic [3:0]  wave;
    logic [2:0]  enemy_respawn;
    logic [7:0]  bg_color;
    logic        game_end;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .N_ENEMIES(3), .LIVES(3), .SCORE_W(16), .WAVE_KILLS(10), .WAVE_W(4), .INVULN_TICKS(60)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause_btn(pause_btn), .frame_tick(frame_tick),
        .enemy_hit(enemy_hit), .enemy_breach(enemy_breach),
        .state(state), .freeze(freeze), .lives(lives), .score(score), .wave(wave),
        .enemy_respawn(enemy_respawn), .bg_color(bg_color), .game_end(game_end)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        frz;
        logic [3:0]  lv;
        logic [15:0] sc;
        logic [3:0]  wv;
        logic [2:0]  rs;
        logic [7:0]  bg;
        logic        ge;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_st = 0, m_lv = 0, m_sc = 0, m_wv = 0, m_k = 0, m_tk = 0;

    function automatic int pop3(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected outputs
    task automatic cyc(input logic r, input logic s, input logic pb, input logic ft,
                       input logic [2:0] h, input logic [2:0] b);
        logic [2:0] rs;
        int n;
        obs_t e;
        @(negedge clk);
        rst = r; start = s; pause_btn = pb; frame_tick = ft; enemy_hit = h; enemy_breach = b;
        rs = 3'b000;
        if (r) begin
            m_st = 0; m_lv = 0; m_sc = 0; m_wv = 0; m_k = 0; m_tk = 0;
        end else begin
            case (m_st)
                0: if (s) begin
                    m_st = 1; m_lv = 3; m_sc = 0; m_wv = 1; m_k = 0; rs = 3'b111;
                end
                4: if (!s) m_st = 0;
                default: begin
                    if (!s) begin
                        m_st = 0;
                    end else if (m_st == 2) begin
                        if (pb) m_st = 1;
                    end else begin
                        rs = h | b;
                        n = pop3(h & ~b);
                        m_sc = (m_sc + n > 65535) ? 65535 : m_sc + n;
                        m_k = m_k + n;
                        if (m_k >= 10) begin
                            m_k = m_k - 10;
                            if (m_wv < 15) m_wv = m_wv + 1;
                        end
                        if (m_st == 1) begin
                            if (b != 3'b000) begin
                                if (m_lv == 1) begin m_lv = 0; m_st = 4; end
                                else begin m_lv = m_lv - 1; m_st = 3; m_tk = 0; end
                            end else if (pb) begin
                                m_st = 2;
                            end
                        end else if (ft) begin
                            m_tk = m_tk + 1;
                            if (m_tk == 60) m_st = 1;
                        end
                    end
                end
            endcase
        end
        e.st  = 3'(m_st);
        e.frz = (m_st == 0 || m_st == 2 || m_st == 4);
        e.lv  = 4'(m_lv);
        e.sc  = 16'(m_sc);
        e.wv  = 4'(m_wv);
        e.rs  = rs;
        e.bg  = (m_st == 1) ? 8'h00 : (m_st == 2) ? 8'h49 : (m_st == 3 || m_st == 4) ? 8'hE0 : 8'hFF;
        e.ge  = (m_st == 4);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every queued expectation is compared against the outputs after its edge
    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, freeze, lives, score, wave, enemy_respawn, bg_color, game_end};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got st=%0d frz=%b lv=%0d sc=%h wv=%0d rs=%b bg=%h ge=%b want st=%0d frz=%b lv=%0d sc=%h wv=%0d rs=%b bg=%h ge=%b",
                         $time, a.st, a.frz, a.lv, a.sc, a.wv, a.rs, a.bg, a.ge,
                         e.st, e.frz, e.lv, e.sc, e.wv, e.rs, e.bg, e.ge);
            end
        end
    end

    task automatic test_reset();
        cyc(1, 0, 0, 0, 3'b000, 3'b000);
        cyc(1, 0, 0, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd0 || lives !== 4'd0 || score !== 16'd0 || wave !== 4'd0 ||
            freeze !== 1'b1 || bg_color !== 8'hFF || game_end !== 1'b0 || enemy_respawn !== 3'b000) begin
            failures++;
            $display("FAIL reset_values: st=%0d lv=%0d sc=%0d wv=%0d frz=%b bg=%h ge=%b rs=%b, want 0 0 0 0 1 ff 0 000",
                     state, lives, score, wave, freeze, bg_color, game_end, enemy_respawn);
        end
    endtask

    task automatic test_start();
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd1 || lives !== 4'd3 || wave !== 4'd1 || score !== 16'd0 || enemy_respawn !== 3'b111) begin
            failures++;
            $display("FAIL start_entry: st=%0d lv=%0d wv=%0d sc=%0d rs=%b, want 1 3 1 0 111",
                     state, lives, wave, score, enemy_respawn);
        end
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        checks++;
        if (enemy_respawn !== 3'b000 || freeze !== 1'b0 || bg_color !== 8'h00) begin
            failures++;
            $display("FAIL start_pulse_end: rs=%b frz=%b bg=%h, want 000 0 00", enemy_respawn, freeze, bg_color);
        end
    endtask

    task automatic test_hits();
        cyc(0, 1, 0, 0, 3'b101, 3'b000);
        checks++;
        if (score !== 16'd2 || enemy_respawn !== 3'b101) begin
            failures++;
            $display("FAIL hit_101: sc=%0d rs=%b, want 2 101", score, enemy_respawn);
        end
        cyc(0, 1, 0, 0, 3'b010, 3'b000);
        checks++;
        if (score !== 16'd3 || enemy_respawn !== 3'b010) begin
            failures++;
            $display("FAIL hit_010: sc=%0d rs=%b, want 3 010", score, enemy_respawn);
        end
        cyc(0, 1, 0, 0, 3'b111, 3'b000);
        cyc(0, 1, 0, 0, 3'b111, 3'b000);
        checks++;
        if (wave !== 4'd1 || score !== 16'd9) begin
            failures++;
            $display("FAIL nine_kills: wv=%0d sc=%0d, want 1 9", wave, score);
        end
        cyc(0, 1, 0, 0, 3'b001, 3'b000);
        checks++;
        if (wave !== 4'd2 || score !== 16'd10) begin
            failures++;
            $display("FAIL wave_advance: wv=%0d sc=%0d, want 2 10", wave, score);
        end
    endtask

    task automatic test_breach_hit();
        cyc(0, 1, 0, 0, 3'b000, 3'b011);
        checks++;
        if (lives !== 4'd2 || state !== 3'd3 || enemy_respawn !== 3'b011 || bg_color !== 8'hE0 || freeze !== 1'b0) begin
            failures++;
            $display("FAIL breach_011: lv=%0d st=%0d rs=%b bg=%h frz=%b, want 2 3 011 e0 0",
                     lives, state, enemy_respawn, bg_color, freeze);
        end
        cyc(0, 1, 0, 0, 3'b000, 3'b100);
        checks++;
        if (lives !== 4'd2 || enemy_respawn !== 3'b100) begin
            failures++;
            $display("FAIL invuln_breach: lv=%0d rs=%b, want 2 100", lives, enemy_respawn);
        end
        cyc(0, 1, 1, 0, 3'b000, 3'b000);
        cyc(0, 1, 0, 0, 3'b001, 3'b000);
        cyc(0, 1, 0, 0, 3'b010, 3'b010);
        checks++;
        if (state !== 3'd3 || score !== 16'd11 || enemy_respawn !== 3'b010) begin
            failures++;
            $display("FAIL hit_in_hit: st=%0d sc=%0d rs=%b, want 3 11 010", state, score, enemy_respawn);
        end
        for (int i = 0; i < 59; i++) cyc(0, 1, 0, 1, 3'b000, 3'b000);
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL tick_59: st=%0d, want 3", state);
        end
        cyc(0, 1, 0, 1, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL tick_60: st=%0d, want 1", state);
        end
    endtask

    task automatic test_pause();
        cyc(0, 1, 1, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd2 || freeze !== 1'b1 || bg_color !== 8'h49) begin
            failures++;
            $display("FAIL pause_enter: st=%0d frz=%b bg=%h, want 2 1 49", state, freeze, bg_color);
        end
        cyc(0, 1, 0, 0, 3'b111, 3'b000);
        cyc(0, 1, 0, 0, 3'b000, 3'b001);
        checks++;
        if (score !== 16'd11 || lives !== 4'd2 || enemy_respawn !== 3'b000) begin
            failures++;
            $display("FAIL pause_ignore: sc=%0d lv=%0d rs=%b, want 11 2 000", score, lives, enemy_respawn);
        end
        cyc(0, 1, 1, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL pause_exit: st=%0d, want 1", state);
        end
    endtask

    task automatic test_abort();
        cyc(0, 0, 1, 0, 3'b010, 3'b001);
        checks++;
        if (state !== 3'd0 || lives !== 4'd2 || score !== 16'd11 || enemy_respawn !== 3'b000) begin
            failures++;
            $display("FAIL abort: st=%0d lv=%0d sc=%0d rs=%b, want 0 2 11 000", state, lives, score, enemy_respawn);
        end
    endtask

    task automatic test_game_over();
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 3'b000, 3'b100);
            if (k < 2) begin
                for (int i = 0; i < 60; i++) cyc(0, 1, 0, 1, 3'b000, 3'b000);
            end
        end
        checks++;
        if (lives !== 4'd0 || state !== 3'd4 || game_end !== 1'b1 || enemy_respawn !== 3'b100 || freeze !== 1'b1) begin
            failures++;
            $display("FAIL game_over: lv=%0d st=%0d ge=%b rs=%b frz=%b, want 0 4 1 100 1",
                     lives, state, game_end, enemy_respawn, freeze);
        end
        cyc(0, 1, 0, 0, 3'b111, 3'b000);
        checks++;
        if (score !== 16'd0 || state !== 3'd4) begin
            failures++;
            $display("FAIL end_hold: sc=%0d st=%0d, want 0 4", score, state);
        end
        cyc(0, 0, 0, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd0 || game_end !== 1'b0) begin
            failures++;
            $display("FAIL end_home: st=%0d ge=%b, want 0 0", state, game_end);
        end
    endtask

    task automatic test_saturation();
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        for (int i = 0; i < 21844; i++) cyc(0, 1, 0, 0, 3'b111, 3'b000);
        cyc(0, 1, 0, 0, 3'b110, 3'b000);
        checks++;
        if (score !== 16'hFFFE || wave !== 4'hF) begin
            failures++;
            $display("FAIL near_max: sc=%h wv=%0d, want fffe 15", score, wave);
        end
        cyc(0, 1, 0, 0, 3'b111, 3'b000);
        checks++;
        if (score !== 16'hFFFF) begin
            failures++;
            $display("FAIL score_sat: sc=%h, want ffff", score);
        end
        cyc(0, 1, 0, 0, 3'b001, 3'b000);
        checks++;
        if (score !== 16'hFFFF || wave !== 4'hF) begin
            failures++;
            $display("FAIL score_hold_max: sc=%h wv=%0d, want ffff 15", score, wave);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1, 1, 0, 0, 3'b111, 3'b001);
        checks++;
        if (state !== 3'd0 || lives !== 4'd0 || score !== 16'd0 || wave !== 4'd0 || enemy_respawn !== 3'b000) begin
            failures++;
            $display("FAIL midgame_reset: st=%0d lv=%0d sc=%0d wv=%0d rs=%b, want 0 0 0 0 000",
                     state, lives, score, wave, enemy_respawn);
        end
        cyc(0, 1, 0, 0, 3'b000, 3'b000);
        checks++;
        if (state !== 3'd1 || lives !== 4'd3 || enemy_respawn !== 3'b111) begin
            failures++;
            $display("FAIL restart: st=%0d lv=%0d rs=%b, want 1 3 111", state, lives, enemy_respawn);
        end
        cyc(0, 1, 0, 0, 3'b100, 3'b000);
        cyc(0, 1, 0, 0, 3'b011, 3'b000);
        checks++;
        if (score !== 16'd3 || enemy_respawn !== 3'b011) begin
            failures++;
            $display("FAIL b2b_hits: sc=%0d rs=%b, want 3 011", score, enemy_respawn);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause_btn = 1'b0; frame_tick = 1'b0;
        enemy_hit = 3'b000; enemy_breach = 3'b000;
        test_reset();
        test_start();
        test_hits();
        test_breach_hit();
        test_pause();
        test_abort();
        test_game_over();
        test_saturation();
        test_back_to_back();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Parametrised game controller for the VGA shooter. It replaces the fixed three-enemy HOME/UPDATE/END sequencer with N enemy channels, multiple lives, a saturating score, wave progression, pause and a post-hit invulnerability window. It sits at the top of the game datapath. It consumes per-enemy hit and breach pulses from collision logic, and drives respawn, freeze, colour and status signals to the movers and the VGA colour path.

## Interface
Parameters:
- N_ENEMIES, 3, number of enemy channels (1..8)
- LIVES, 3, lives loaded at game start (1..15)
- SCORE_W, 16, score width
- WAVE_KILLS, 10, kills per wave advance (≥1)
- WAVE_W, 4, wave counter width
- INVULN_TICKS, 60, frame ticks spent in HIT state (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- start  in  1  level; high = run game, low = return home
- pause_btn  in  1  single-cycle pulse; toggles PLAY/PAUSE
- frame_tick  in  1  single-cycle pulse once per video frame
- enemy_hit  in  N_ENEMIES  per-enemy pulse: enemy killed by projectile
- enemy_breach  in  N_ENEMIES  per-enemy pulse: enemy reached player row
- state  out  3  HOME=0, PLAY=1, PAUSE=2, HIT=3, END=4
- freeze  out  1  high when movers must hold position
- lives  out  4  remaining lives
- score  out  SCORE_W  saturating score
- wave  out  WAVE_W  current wave, starts at 1
- enemy_respawn  out  N_ENEMIES  one-cycle pulse per enemy to respawn
- bg_color  out  8  RGB332 background colour
- game_end  out  1  high while in END

## Operation
- Reset: state=HOME, lives=0, score=0, wave=0, kill count=0, enemy_respawn=0, freeze=1, bg_color=8'hFF, game_end=0.
- HOME: freeze=1, bg_color=8'hFF.
  - start high → PLAY.
  - On entry to PLAY: lives=LIVES, score=0, wave=1, kills=0, enemy_respawn=all ones for one cycle.
- PLAY: freeze=0, bg_color=8'h00.
  - Accepted hits: score += popcount(enemy_hit), saturating at 2^SCORE_W−1.
  - kills += popcount(enemy_hit). When kills ≥ WAVE_KILLS: kills −= WAVE_KILLS, wave += 1, saturating at 2^WAVE_W−1.
  - Any breach bit set: lives −= 1, exactly once per cycle regardless of how many bits are set.
  - If lives was 1 before the breach → END with lives=0. Otherwise → HIT with the tick counter cleared.
- HIT: freeze=0, bg_color=8'hE0.
  - Hits are scored as in PLAY. Breaches are ignored for lives but still respawn.
  - Counts frame_tick. At INVULN_TICKS ticks → PLAY.
  - pause_btn is ignored.
- PAUSE: freeze=1, bg_color=8'h49.
  - enemy_hit and enemy_breach are ignored entirely (no score, no respawn).
  - pause_btn → PLAY.
- pause_btn in PLAY → PAUSE.
- start low in PLAY/PAUSE/HIT → HOME. This takes priority over breach, pause and hit in the same cycle; that cycle's hits are not scored.
- END: freeze=1, game_end=1, bg_color=8'hE0. Score, wave and lives hold. start low → HOME.
- Respawn: enemy_respawn[i] pulses for one cycle when hit[i] or breach[i] is accepted in PLAY or HIT.
  - A breach that ends the game still pulses respawn.
  - If hit[i] and breach[i] are both set, it counts as a breach: no score, no kill.
- Values of lives and score are never held below 0 or wrapped above their maximum.

## Timing
- All outputs are registered. A response appears on the clock edge after the causing input: one-cycle latency for state, score, lives, wave and respawn.
- freeze, bg_color, game_end and state are decoded from registered state. They change in the cycle the new state becomes visible.
- Inputs are sampled every clk edge. Pulses longer than one cycle are counted once per cycle high; upstream must deliver single-cycle pulses.
- The HIT timer counts frame_tick edges only. INVULN_TICKS=60 is about 1 s at 60 Hz.
- Reset asserted mid-game forces the reset values on the next edge, from any state. No respawn pulse is issued.

## Test plan
- Reset then start=1 → next edge state=1, lives=3, score=0, wave=1, enemy_respawn=3'b111 for exactly one cycle.
- In PLAY, enemy_hit=3'b101 one cycle, then 3'b010 → score=2 then 3, respawn pulses match each hit. Ten total kills → wave=2.
- Set score=16'hFFFE, hit=3'b111 → score saturates at 16'hFFFF.
- Breach 3'b011 in PLAY with lives=3 → lives=2 (not 1), state=HIT. A further breach during HIT leaves lives=2. After 60 frame_ticks → PLAY.
- Three separate breaches (each after the HIT window) → lives=0, state=END, game_end=1. start=0 → HOME, game_end=0.
- pause_btn in PLAY → state=2, freeze=1, hits ignored (score unchanged). pause_btn → PLAY. start=0 together with breach → HOME, lives unchanged.
